// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multi-digit seven-segment scan controller with shift-add-3 BCD.
// Optional macro SEG_LZ_BLANK_EN blanks leading zeros of decimal values.
module seg_scan_ctrl #(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 100_000,
    parameter int NUM_SRC = 8,
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC*32-1:0] src_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM_SRC-1:0]   dec_mask,
    output logic [7:0]           SEG,
    output logic [DIGITS-1:0]    AN,
    output logic                 busy,
    output logic                 ovf
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int DW    = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        state_q, state_d;
    logic [39:0]       bcd_q, bcd_d;
    logic [31:0]       bin_q, bin_d;
    logic [4:0]        bit_q, bit_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic [DW-1:0]     disp_q, disp_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic              tick;
    logic              wrap;
    logic [31:0]       src_sel;
    logic              dec_sel;
    logic [39:0]       bcd_adj;
    logic [3:0]        nib;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'hC0;
            4'h1: seg7 = 8'hF9;
            4'h2: seg7 = 8'hA4;
            4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;
            4'h5: seg7 = 8'h92;
            4'h6: seg7 = 8'h82;
            4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;
            4'h9: seg7 = 8'h90;
            4'hA: seg7 = 8'h88;
            4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;
            4'hD: seg7 = 8'hA1;
            4'hE: seg7 = 8'h86;
            default: seg7 = 8'h8E;
        endcase
    endfunction

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign wrap = tick && (idx_q == IDX_W'(DIGITS - 1));

    // Prescaler and digit index stepping
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
    end

    // Source mux; out-of-range select reads as hex zero
    always_comb begin
        src_sel = '0;
        dec_sel = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                src_sel = src_data[k*32 +: 32];
                dec_sel = dec_mask[k];
            end
        end
    end

    // Add 3 to every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 10; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic dmode_q, dmode_d;
`endif

    // Frame sampling and binary-to-BCD converter FSM
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
`ifdef SEG_LZ_BLANK_EN
        dmode_d = dmode_q;
`endif
        if (wrap) begin
            if (!dec_sel) begin
                disp_d = src_sel[DW-1:0];
`ifdef SEG_LZ_BLANK_EN
                dmode_d = 1'b0;
`endif
            end else if (state_q == S_IDLE) begin
                state_d = S_LOAD;
                bin_d   = src_sel;
            end
        end
        case (state_q)
            S_LOAD: begin
                bcd_d   = '0;
                bit_d   = 5'd31;
                busy_d  = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                bcd_d = {bcd_adj[38:0], bin_q[31]};
                bin_d = {bin_q[30:0], 1'b0};
                if (bit_q == 5'd0) begin
                    state_d = S_DONE;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            S_DONE: begin
                disp_d  = bcd_q[DW-1:0];
                ovf_d   = |bcd_q[39:DW];
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef SEG_LZ_BLANK_EN
                dmode_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign nib = disp_q[{idx_q, 2'b00} +: 4];

    // Segment and anode decode for the current digit
    always_comb begin
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = seg7(nib);
`ifdef SEG_LZ_BLANK_EN
        if (dmode_q && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0)) begin
            seg_d = 8'hFF;
        end
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
`ifdef SEG_LZ_BLANK_EN
            dmode_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
`ifdef SEG_LZ_BLANK_EN
            dmode_q <= dmode_d;
`endif
        end
    end

    assign SEG  = seg_q;
    assign AN   = an_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan, hex, decimal, overflow,
// busy-drop and reset behaviour on three parameterisations.
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0 = 1'b1;
    logic [255:0] src0 = '0;
    logic [2:0]   sel0 = '0;
    logic [7:0]   dec0 = '0;
    logic [7:0]   seg0;
    logic [7:0]   an0;
    logic         busy0, ovf0;

    logic         rst1 = 1'b1;
    logic [63:0]  src1 = '0;
    logic         sel1 = 1'b0;
    logic [1:0]   dec1 = '0;
    logic [7:0]   seg1;
    logic [3:0]   an1;
    logic         busy1, ovf1;

    logic         rst2 = 1'b1;
    logic [95:0]  src2 = '0;
    logic [1:0]   sel2 = '0;
    logic [2:0]   dec2 = '0;
    logic [7:0]   seg2;
    logic [7:0]   an2;
    logic         busy2, ovf2;

    seg_scan_ctrl #(.DIGITS(8), .CLK_DIV(4), .NUM_SRC(8)) u0 (
        .clk(clk), .rst(rst0), .src_data(src0), .sel(sel0),
        .dec_mask(dec0), .SEG(seg0), .AN(an0), .busy(busy0), .ovf(ovf0)
    );
    seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(4), .NUM_SRC(2)) u1 (
        .clk(clk), .rst(rst1), .src_data(src1), .sel(sel1),
        .dec_mask(dec1), .SEG(seg1), .AN(an1), .busy(busy1), .ovf(ovf1)
    );
    seg_scan_ctrl #(.DIGITS(8), .CLK_DIV(1), .NUM_SRC(3)) u2 (
        .clk(clk), .rst(rst2), .src_data(src2), .sel(sel2),
        .dec_mask(dec2), .SEG(seg2), .AN(an2), .busy(busy2), .ovf(ovf2)
    );

    typedef struct {
        int         t;
        logic [7:0] seg;
        logic [7:0] an;
    } vec_t;

    vec_t hv[9];
    int   nvec  = 0;
    int   nfail = 0;
    int   t     = 0;
    int   bc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic go(input int n);
        while (t < n) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic rst_pulse(input int w);
        case (w)
            0: rst0 = 1'b1;
            1: rst1 = 1'b1;
            default: rst2 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        case (w)
            0: rst0 = 1'b0;
            1: rst1 = 1'b0;
            default: rst2 = 1'b0;
        endcase
        t = 0;
    endtask

    initial begin
        hv[0] = '{33, 8'h8E, 8'hFE};
        hv[1] = '{37, 8'h86, 8'hFD};
        hv[2] = '{41, 8'h86, 8'hFB};
        hv[3] = '{45, 8'h83, 8'hF7};
        hv[4] = '{49, 8'hA1, 8'hEF};
        hv[5] = '{53, 8'h88, 8'hDF};
        hv[6] = '{57, 8'h86, 8'hBF};
        hv[7] = '{61, 8'hA1, 8'h7F};
        hv[8] = '{65, 8'h8E, 8'hFE};

        // DIGITS=8, CLK_DIV=4: reset, prescaler, hex scan
        src0[31:0]  = 32'hDEADBEEF;
        src0[63:32] = 32'd12345678;
        rst_pulse(0);
        chk("rst_seg", 32'(seg0), 32'hFF);
        chk("rst_an", 32'(an0), 32'hFF);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_ovf", 32'(ovf0), 32'h0);
        go(4);
        chk("an_t4", 32'(an0), 32'hFE);
        go(5);
        chk("an_t5", 32'(an0), 32'hFD);
        for (int i = 0; i < 9; i++) begin
            go(hv[i].t);
            chk($sformatf("hex_seg%0d", i), 32'(seg0), 32'(hv[i].seg));
            chk($sformatf("hex_an%0d", i), 32'(an0), 32'(hv[i].an));
        end

        // Decimal conversion latency and busy length
        sel0 = 3'd1;
        dec0 = 8'h02;
        go(96);
        chk("dec_busy_t0", 32'(busy0), 32'h0);
        bc = 0;
        for (int k = 97; k <= 129; k++) begin
            go(k);
            if (busy0) bc++;
        end
        chk("dec_busy_len", 32'(bc), 32'd33);
        chk("dec_disp_t33", u0.disp_q, 32'hDEADBEEF);
        go(130);
        chk("dec_disp_t34", u0.disp_q, 32'h12345678);
        chk("dec_busy_end", 32'(busy0), 32'h0);
        chk("dec_ovf", 32'(ovf0), 32'h0);
        go(133);
        chk("dec_seg_idx1", 32'(seg0), 32'hF8);
        go(161);
        chk("dec_seg_idx0", 32'(seg0), 32'h80);
        chk("dec_an_idx0", 32'(an0), 32'hFE);

        // Reset in the middle of SHIFT
        go(170);
        chk("mid_busy", 32'(busy0), 32'h1);
        rst_pulse(0);
        chk("mid_rst_seg", 32'(seg0), 32'hFF);
        chk("mid_rst_an", 32'(an0), 32'hFF);
        chk("mid_rst_busy", 32'(busy0), 32'h0);
        chk("mid_rst_disp", u0.disp_q, 32'h0);
        go(4);
        chk("mid_an_t4", 32'(an0), 32'hFE);
        go(5);
        chk("mid_an_t5", 32'(an0), 32'hFD);
        go(31);
        chk("mid_no_write", u0.disp_q, 32'h0);

        // DIGITS=4: overflow then in-range value
        src1[31:0] = 32'd123456;
        sel1 = 1'b0;
        dec1 = 2'b01;
        rst_pulse(1);
        go(49);
        chk("ovf_disp_pre", 32'(u1.disp_q), 32'h0);
        chk("ovf_pre", 32'(ovf1), 32'h0);
        go(50);
        chk("ovf_disp", 32'(u1.disp_q), 32'h3456);
        chk("ovf_set", 32'(ovf1), 32'h1);
        src1[31:0] = 32'd9999;
        go(53);
        chk("ovf_seg_idx1", 32'(seg1), 32'h92);
        chk("ovf_an_idx1", 32'(an1), 32'hD);
        go(97);
        chk("ovf_hold", 32'(ovf1), 32'h1);
        chk("ovf_disp_hold", 32'(u1.disp_q), 32'h3456);
        go(98);
        chk("ovf_disp2", 32'(u1.disp_q), 32'h9999);
        chk("ovf_clr", 32'(ovf1), 32'h0);

        // CLK_DIV=1: frame starts during conversion are dropped
        src2[31:0] = 32'd7;
        sel2 = 2'd0;
        dec2 = 3'b001;
        rst_pulse(2);
        go(10);
        src2[31:0] = 32'd9;
        go(41);
        chk("drop_disp_pre", u2.disp_q, 32'h0);
        go(42);
        chk("drop_disp7", u2.disp_q, 32'h7);
        go(47);
        chk("drop_busy_idle", 32'(busy2), 32'h0);
        go(49);
        chk("drop_busy_run", 32'(busy2), 32'h1);
        go(81);
        chk("drop_disp7_hold", u2.disp_q, 32'h7);
        go(82);
        chk("drop_disp9", u2.disp_q, 32'h9);
        sel2 = 2'd3;
        go(87);
        chk("oor_pre", u2.disp_q, 32'h9);
        go(88);
        chk("oor_zero", u2.disp_q, 32'h0);

`ifdef SEG_LZ_BLANK_EN
        sel2 = 2'd0;
        src2[31:0] = 32'd42;
        go(137);
        chk("lz_idx0", 32'(seg2), 32'hA4);
        go(138);
        chk("lz_idx1", 32'(seg2), 32'h99);
        for (int k = 139; k <= 144; k++) begin
            go(k);
            chk($sformatf("lz_idx%0d", k - 137), 32'(seg2), 32'hFF);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
